// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared cpu types: bus word, RAM status encoding and cache block geometry.
// Two-word (8-byte) blocks; word 0 at offset 0, word 1 at offset 4.
package coherence_bus_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam word_t WORD0_OFF  = 32'h0000_0000;
  localparam word_t WORD1_OFF  = 32'h0000_0004;
  localparam word_t BLOCK_MASK = 32'hFFFF_FFF8;

  // Base address of the block containing a byte address.
  function automatic word_t block_addr(input word_t addr);
    return addr & BLOCK_MASK;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Core-side and RAM-side signal bundle of the coherence bus controller.
// master: the controller's view; slave: the cores' and RAM's view.
interface coherence_bus_ctrl_if #(
  parameter int CPUS = 2
);
  import coherence_bus_ctrl_pkg::*;

  // instruction fetch
  logic [CPUS-1:0]  iREN;
  word_t [CPUS-1:0] iaddr;
  logic [CPUS-1:0]  iwait;
  word_t [CPUS-1:0] iload;
  // data access
  logic [CPUS-1:0]  dREN;
  logic [CPUS-1:0]  dWEN;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic [CPUS-1:0]  dwait;
  word_t [CPUS-1:0] dload;
  // coherence
  logic [CPUS-1:0]  cctrans;
  logic [CPUS-1:0]  ccwrite;
  logic [CPUS-1:0]  ccwait;
  logic [CPUS-1:0]  ccinv;
  word_t [CPUS-1:0] ccsnoopaddr;
  // RAM
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/bus_rr_arbiter.sv
// Picks one core for the next data transaction: writebacks beat coherence requests.
// Latency: combinational grant; priority pointer updates on the cycle the grant is taken.
// Backpressure: none; the grant is only consumed when grant_en is high.
module bus_rr_arbiter #(
  parameter int CPUS = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] wb_req,
  input  logic [CPUS-1:0] cc_req,
  input  logic            grant_en,
  output logic            grant_vld,
  output logic            grant_core,
  output logic            grant_wb
);

  logic            ptr;
  logic [CPUS-1:0] cls;

  // Highest-priority request class wins; ties inside the class go to ptr.
  always_comb begin
    grant_wb   = |wb_req;
    cls        = grant_wb ? wb_req : cc_req;
    grant_vld  = |cls;
    grant_core = (cls[0] & cls[1]) ? ptr : cls[1];
  end

  // Pointer flips after every granted transaction so a contending core goes next.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= 1'b0;
    end else if (grant_en && grant_vld) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping bus controller: arbitrates writebacks, coherence misses and fetches onto one RAM.
// Latency: IDLE->ARB->SNOOP then one word per RAM ACCESS cycle; fetches one word from IDLE.
// Backpressure: ramstate other than ACCESS (ERROR included) holds the state; cores stall on dwait/iwait.
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int CPUS = 2  // only 2 cores are supported
) (
  input logic                  CLK,
  input logic                  nRST,
  coherence_bus_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, ARB, SNOOP, WB1, WB2, C2C1, C2C2, LD1, LD2, IFETCH
  } state_t;

  state_t          state, next_state;
  logic            gnt_core, next_gnt_core;
  logic            gnt_ccwrite, next_gnt_ccwrite;
  logic            if_core, next_if_core;
  logic [CPUS-1:0] wb_req, cc_req, data_req;
  logic            arb_vld, arb_core, arb_wb, arb_take;
  logic            snp;
  logic            access;

  // A core raising dWEN is evicting, even if it also has a coherence request pending.
  assign wb_req   = bus.dWEN;
  assign cc_req   = bus.cctrans & ~bus.dWEN;
  assign data_req = bus.dREN | bus.dWEN;
  assign snp      = ~gnt_core;
  assign access   = (bus.ramstate == ACCESS);

  bus_rr_arbiter #(.CPUS(CPUS)) u_arb (
    .CLK       (CLK),
    .nRST      (nRST),
    .wb_req    (wb_req),
    .cc_req    (cc_req),
    .grant_en  (arb_take),
    .grant_vld (arb_vld),
    .grant_core(arb_core),
    .grant_wb  (arb_wb)
  );

  // State and latched grant; reset drops any transaction in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      gnt_core    <= 1'b0;
      gnt_ccwrite <= 1'b0;
      if_core     <= 1'b0;
    end else begin
      state       <= next_state;
      gnt_core    <= next_gnt_core;
      gnt_ccwrite <= next_gnt_ccwrite;
      if_core     <= next_if_core;
    end
  end

  // Next state and all bus outputs; waiting cores see wait=1 until their word lands.
  always_comb begin
    next_state       = state;
    next_gnt_core    = gnt_core;
    next_gnt_ccwrite = gnt_ccwrite;
    next_if_core     = if_core;
    arb_take         = 1'b0;

    bus.iwait       = bus.iREN;
    bus.iload       = '0;
    bus.dwait       = data_req;
    bus.dload       = '0;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;

    case (state)
      IDLE: begin
        if (|(bus.cctrans | bus.dWEN)) begin
          next_state = ARB;
        end else if (|bus.iREN) begin
          next_state   = IFETCH;
          next_if_core = ~bus.iREN[0];
        end
      end

      ARB: begin
        if (arb_vld) begin
          arb_take         = 1'b1;
          next_gnt_core    = arb_core;
          next_gnt_ccwrite = bus.ccwrite[arb_core];
          next_state       = arb_wb ? WB1 : SNOOP;
        end else begin
          next_state = IDLE;
        end
      end

      WB1, WB2: begin
        bus.ramWEN          = 1'b1;
        bus.ramaddr         = bus.daddr[gnt_core];
        bus.ramstore        = bus.dstore[gnt_core];
        bus.dwait[gnt_core] = ~access;
        if (access) next_state = (state == WB1) ? WB2 : IDLE;
      end

      SNOOP: begin
        bus.ccwait[snp]      = 1'b1;
        bus.ccsnoopaddr[snp] = bus.daddr[gnt_core];
        bus.ccinv[snp]       = gnt_ccwrite;
        if (bus.cctrans[snp]) next_state = bus.ccwrite[snp] ? C2C1 : LD1;
      end

      // Snooper owns the dirty block: its words go to the requester and back to RAM.
      C2C1, C2C2: begin
        bus.ccwait[snp]      = 1'b1;
        bus.ccsnoopaddr[snp] = bus.daddr[gnt_core];
        bus.ramWEN           = 1'b1;
        bus.ramaddr          = bus.daddr[snp];
        bus.ramstore         = bus.dstore[snp];
        bus.dload[gnt_core]  = bus.dstore[snp];
        bus.dwait[gnt_core]  = ~access;
        bus.dwait[snp]       = data_req[snp] & ~access;
        if (access) next_state = (state == C2C1) ? C2C2 : IDLE;
      end

      LD1, LD2: begin
        bus.ccwait[snp]      = 1'b1;
        bus.ccsnoopaddr[snp] = bus.daddr[gnt_core];
        bus.ramREN           = 1'b1;
        bus.ramaddr          = block_addr(bus.daddr[gnt_core]) +
                               ((state == LD1) ? WORD0_OFF : WORD1_OFF);
        bus.dload[gnt_core]  = bus.ramload;
        bus.dwait[gnt_core]  = ~access;
        if (access) next_state = (state == LD1) ? LD2 : IDLE;
      end

      IFETCH: begin
        bus.ramREN         = 1'b1;
        bus.ramaddr        = bus.iaddr[if_core];
        bus.iload[if_core] = bus.ramload;
        bus.iwait[if_core] = ~access;
        if (access) next_state = IDLE;
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: misses, cache-to-cache, arbitration, stalls, reset, fetch.
// Latency: checks sampled 2 time units after the rising edge, inputs driven 1 unit after it.
// Backpressure: ramstate is stepped by hand to exercise BUSY/ERROR holds.
module tb_coherence_bus_ctrl;
  import coherence_bus_ctrl_pkg::*;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;
  logic [1:0] seen;

  coherence_bus_ctrl_if #(.CPUS(2)) b ();

  coherence_bus_ctrl #(.CPUS(2)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clr;
    b.iREN     = '0;
    b.iaddr    = '0;
    b.dREN     = '0;
    b.dWEN     = '0;
    b.daddr    = '0;
    b.dstore   = '0;
    b.cctrans  = '0;
    b.ccwrite  = '0;
    b.ramload  = '0;
    b.ramstate = BUSY;
  endtask

  // Waits for the next rising edge of ccwait (a new SNOOP), bounded.
  task automatic wait_snoop(output logic [1:0] got);
    int n;
    n = 0;
    while (b.ccwait != 2'b00 && n < 20) begin tick; #1; n++; end
    while (b.ccwait == 2'b00 && n < 20) begin tick; #1; n++; end
    got = b.ccwait;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nRST  = 1'b0;
    clr;
    b.ramstate = FREE;
    tick; #1;
    chk("rst_ramREN", b.ramREN, 0);
    chk("rst_ramWEN", b.ramWEN, 0);
    chk("rst_ccwait", b.ccwait, 0);
    chk("rst_ccinv", b.ccinv, 0);
    chk("rst_dwait_idle", b.dwait, 0);
    chk("rst_iwait_idle", b.iwait, 0);
    b.iREN[1] = 1'b1;
    b.dREN[0] = 1'b1;
    #1;
    chk("rst_iwait_follow", b.iwait, 2'b10);
    chk("rst_dwait_follow", b.dwait, 2'b01);
    chk("rst_dload", b.dload[0], 0);
    clr;
    tick;
    nRST = 1'b1;
    tick;

    // core0 read miss, core1 has no copy -> RAM load of 0x100/0x104
    b.dREN[0] = 1'b1; b.cctrans[0] = 1'b1; b.daddr[0] = 32'h100;
    #1;
    chk("a_idle_dwait", b.dwait, 2'b01);
    tick;
    tick; #1;
    chk("a_snoop_ccwait", b.ccwait, 2'b10);
    chk("a_snoop_addr", b.ccsnoopaddr[1], 32'h100);
    chk("a_snoop_ccinv", b.ccinv, 0);
    chk("a_snoop_dwait", b.dwait, 2'b01);
    b.cctrans[1] = 1'b1;
    tick;
    b.cctrans[1] = 1'b0; b.ramstate = ACCESS; b.ramload = 32'h1111_1111;
    #1;
    chk("a_ld1_ren", b.ramREN, 1);
    chk("a_ld1_addr", b.ramaddr, 32'h100);
    chk("a_ld1_dload", b.dload[0], 32'h1111_1111);
    chk("a_ld1_dwait", b.dwait, 2'b00);
    chk("a_ld1_ccwait", b.ccwait, 2'b10);
    tick;
    b.ramload = 32'h2222_2222;
    #1;
    chk("a_ld2_addr", b.ramaddr, 32'h104);
    chk("a_ld2_dload", b.dload[0], 32'h2222_2222);
    chk("a_ld2_ccwait", b.ccwait, 2'b10);
    tick;
    clr; #1;
    chk("a_done_ccwait", b.ccwait, 0);
    chk("a_done_ren", b.ramREN, 0);

    // core1 write miss, core0 holds 0x200 MODIFIED -> cache-to-cache
    b.dREN[1] = 1'b1; b.cctrans[1] = 1'b1; b.ccwrite[1] = 1'b1; b.daddr[1] = 32'h200;
    #1;
    tick;
    tick; #1;
    chk("b_snoop_ccinv", b.ccinv, 2'b01);
    chk("b_snoop_ccwait", b.ccwait, 2'b01);
    chk("b_snoop_addr", b.ccsnoopaddr[0], 32'h200);
    b.cctrans[0] = 1'b1; b.ccwrite[0] = 1'b1; b.daddr[0] = 32'h200; b.dstore[0] = 32'hDEAD_BEEF;
    tick; #1;
    chk("b_c2c1_busy_dwait", b.dwait, 2'b10);
    b.ramstate = ACCESS;
    #1;
    chk("b_c2c1_wen", b.ramWEN, 1);
    chk("b_c2c1_ren", b.ramREN, 0);
    chk("b_c2c1_addr", b.ramaddr, 32'h200);
    chk("b_c2c1_store", b.ramstore, 32'hDEAD_BEEF);
    chk("b_c2c1_dload", b.dload[1], 32'hDEAD_BEEF);
    chk("b_c2c1_dwait", b.dwait, 2'b00);
    chk("b_c2c1_ccwait", b.ccwait, 2'b01);
    tick;
    b.daddr[0] = 32'h204; b.dstore[0] = 32'hCAFE_F00D;
    #1;
    chk("b_c2c2_addr", b.ramaddr, 32'h204);
    chk("b_c2c2_store", b.ramstore, 32'hCAFE_F00D);
    chk("b_c2c2_dload", b.dload[1], 32'hCAFE_F00D);
    tick;
    clr; #1;
    chk("b_done_wen", b.ramWEN, 0);

    // both cores miss continuously -> grants 0, 1, 0
    b.dREN = 2'b11; b.cctrans = 2'b11; b.daddr[0] = 32'h400; b.daddr[1] = 32'h500;
    b.ramstate = ACCESS;
    #1;
    wait_snoop(seen);
    chk("c_grant1", seen, 2'b10);
    wait_snoop(seen);
    chk("c_grant2", seen, 2'b01);
    tick; #1;
    chk("c_grant2_addr", b.ramaddr, 32'h500);
    wait_snoop(seen);
    chk("c_grant3", seen, 2'b10);
    tick;
    tick;
    tick;
    clr; #1;

    // core0 eviction + core1 miss together -> writeback first, then SNOOP for core1
    b.dWEN[0] = 1'b1; b.daddr[0] = 32'h600; b.dstore[0] = 32'hAAAA_0000;
    b.dREN[1] = 1'b1; b.cctrans[1] = 1'b1; b.daddr[1] = 32'h700;
    #1;
    chk("d_idle_dwait", b.dwait, 2'b11);
    tick;
    tick; #1;
    chk("d_wb1_wen", b.ramWEN, 1);
    chk("d_wb1_addr", b.ramaddr, 32'h600);
    chk("d_wb1_store", b.ramstore, 32'hAAAA_0000);
    chk("d_wb1_ccwait", b.ccwait, 0);
    chk("d_wb1_busy_dwait", b.dwait, 2'b11);
    b.ramstate = ACCESS;
    #1;
    chk("d_wb1_acc_dwait", b.dwait, 2'b10);
    tick;
    b.daddr[0] = 32'h604; b.dstore[0] = 32'hAAAA_0004;
    #1;
    chk("d_wb2_addr", b.ramaddr, 32'h604);
    chk("d_wb2_store", b.ramstore, 32'hAAAA_0004);
    tick;
    b.dWEN[0] = 1'b0;
    #1;
    wait_snoop(seen);
    chk("d_snoop_after_wb", seen, 2'b01);
    // LD1 with BUSY x3, ERROR x1, then ACCESS
    b.cctrans[0] = 1'b1; b.ramstate = BUSY;
    for (int i = 0; i < 3; i++) begin
      tick; #1;
      chk("d_ld1_busy_addr", b.ramaddr, 32'h700);
      chk("d_ld1_busy_dwait", b.dwait, 2'b10);
    end
    tick;
    b.ramstate = ERROR;
    #1;
    chk("d_ld1_err_addr", b.ramaddr, 32'h700);
    chk("d_ld1_err_dwait", b.dwait, 2'b10);
    tick;
    b.ramstate = ACCESS; b.ramload = 32'h7777_0000;
    #1;
    chk("d_ld1_acc_addr", b.ramaddr, 32'h700);
    chk("d_ld1_acc_dwait", b.dwait, 2'b00);
    chk("d_ld1_acc_dload", b.dload[1], 32'h7777_0000);
    tick;
    b.ramload = 32'h7777_0004;
    #1;
    chk("d_ld2_addr", b.ramaddr, 32'h704);
    chk("d_ld2_dload", b.dload[1], 32'h7777_0004);
    tick;
    clr; #1;

    // same core evicting and missing at once -> writeback first
    b.dWEN[1] = 1'b1; b.cctrans[1] = 1'b1; b.daddr[1] = 32'h900; b.dstore[1] = 32'h5555_5555;
    #1;
    tick;
    tick; #1;
    chk("e_wb_first_wen", b.ramWEN, 1);
    chk("e_wb_first_addr", b.ramaddr, 32'h900);
    chk("e_wb_first_ccwait", b.ccwait, 0);
    b.ramstate = ACCESS;
    tick;
    tick;
    b.dWEN[1] = 1'b0; b.dREN[1] = 1'b1;
    #1;
    wait_snoop(seen);
    chk("e_snoop_after_wb", seen, 2'b01);
    b.cctrans[0] = 1'b1;
    tick;
    tick;
    tick;
    clr; #1;

    // reset asserted during C2C2
    b.dREN[0] = 1'b1; b.cctrans[0] = 1'b1; b.ccwrite[0] = 1'b1; b.daddr[0] = 32'h800;
    b.ramstate = ACCESS;
    #1;
    wait_snoop(seen);
    chk("f_snoop", seen, 2'b10);
    chk("f_snoop_ccinv", b.ccinv, 2'b10);
    b.cctrans[1] = 1'b1; b.ccwrite[1] = 1'b1; b.daddr[1] = 32'h800; b.dstore[1] = 32'h1234_5678;
    tick;
    tick;
    b.daddr[1] = 32'h804; b.dstore[1] = 32'h9ABC_DEF0;
    #1;
    chk("f_c2c2_wen", b.ramWEN, 1);
    chk("f_c2c2_addr", b.ramaddr, 32'h804);
    nRST = 1'b0;
    #1;
    chk("f_rst_wen", b.ramWEN, 0);
    chk("f_rst_ccwait", b.ccwait, 0);
    chk("f_rst_dwait", b.dwait, 2'b01);
    tick; #1;
    chk("f_rst_edge_wen", b.ramWEN, 0);
    chk("f_rst_edge_ccwait", b.ccwait, 0);
    clr;
    tick;
    nRST = 1'b1;
    #1;
    chk("f_release_ren", b.ramREN, 0);
    tick;

    // instruction fetch: lower core first, one word each
    b.iREN = 2'b11; b.iaddr[0] = 32'h1000; b.iaddr[1] = 32'h2000;
    #1;
    chk("g_idle_iwait", b.iwait, 2'b11);
    chk("g_idle_ren", b.ramREN, 0);
    tick; #1;
    chk("g_f0_ren", b.ramREN, 1);
    chk("g_f0_addr", b.ramaddr, 32'h1000);
    chk("g_f0_busy_iwait", b.iwait, 2'b11);
    b.ramstate = ACCESS; b.ramload = 32'hF00D_0000;
    #1;
    chk("g_f0_acc_iwait", b.iwait, 2'b10);
    chk("g_f0_iload", b.iload[0], 32'hF00D_0000);
    tick;
    b.iREN[0] = 1'b0;
    #1;
    chk("g_mid_iwait", b.iwait, 2'b10);
    tick;
    b.ramload = 32'hBEEF_0001;
    #1;
    chk("g_f1_addr", b.ramaddr, 32'h2000);
    chk("g_f1_iwait", b.iwait, 2'b00);
    chk("g_f1_iload", b.iload[1], 32'hBEEF_0001);
    tick;
    clr; #1;
    chk("g_done_ren", b.ramREN, 0);
    chk("g_done_iwait", b.iwait, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
